// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard unit.
// The master side (datapath) supplies decode/execute status, and the slave side
// (hazard unit) returns the stall, flush and freeze controls.
interface pipeline_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_memread;
   logic [4:0]  ex_wr_reg;
   logic        ex_md_start;
   logic        id_redirect;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        ex_hold;
   logic        md_done;
   logic [15:0] stall_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_memread, ex_wr_reg, ex_md_start, id_redirect,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, md_done, stall_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_memread, ex_wr_reg, ex_md_start, id_redirect,
      output pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, md_done, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline. It detects load-use hazards and
// redirect flushes, and it freezes the pipeline while a multi-cycle mul/div
// instruction occupies EX. It also keeps a saturating count of PC-stall cycles.
module pipeline_hazard_ctrl #(
   parameter int MD_LAT = 8
) (
   input  logic clk,
   input  logic reset,
   pipeline_hazard_ctrl_if.slave bus
);

   typedef enum logic {IDLE, MD_BUSY} state_t;

   localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

   state_t      state, state_nxt;
   logic [3:0]  md_cnt, md_cnt_nxt;
   logic        md_done_q, md_done_nxt;
   logic [15:0] stall_cnt_q;
   logic        md_start_q;
   logic        load_use;
   logic        frozen;

   // Saturating increment so the stall counter sticks at its maximum.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Hazard detection. A new mul/div start is recognised only from IDLE and
   // never in the md_done cycle, so the instruction held in EX can advance.
   always_comb begin
      md_start_q = bus.ex_md_start && (state == IDLE) && !md_done_q;
      load_use   = bus.ex_memread && (bus.ex_wr_reg != 5'd0) &&
                   ((bus.ex_wr_reg == bus.id_rs) ||
                    (bus.id_uses_rt && (bus.ex_wr_reg == bus.id_rt)));
      frozen     = (state == MD_BUSY) || md_start_q;
   end

   // Next-state logic for the mul/div freeze sequencer.
   always_comb begin
      state_nxt   = state;
      md_cnt_nxt  = md_cnt;
      md_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (md_start_q) begin
               if (MD_LAT > 1) begin
                  state_nxt  = MD_BUSY;
                  md_cnt_nxt = MD_LOAD;
               end else begin
                  md_done_nxt = 1'b1;
               end
            end
         end
         MD_BUSY: begin
            if (md_cnt == 4'd1) begin
               state_nxt   = IDLE;
               md_cnt_nxt  = 4'd0;
               md_done_nxt = 1'b1;
            end else begin
               md_cnt_nxt = md_cnt - 4'd1;
            end
         end
         default: begin
            state_nxt  = IDLE;
            md_cnt_nxt = 4'd0;
         end
      endcase
   end

   // Pipeline control outputs with priority freeze > load-use > redirect > normal.
   // All controls are held low while reset is asserted.
   always_comb begin
      bus.pc_write    = 1'b1;
      bus.ifid_write  = 1'b1;
      bus.ifid_flush  = 1'b0;
      bus.idex_bubble = 1'b0;
      bus.ex_hold     = 1'b0;
      if (reset) begin
         bus.pc_write   = 1'b0;
         bus.ifid_write = 1'b0;
      end else if (frozen) begin
         bus.pc_write   = 1'b0;
         bus.ifid_write = 1'b0;
         bus.ex_hold    = 1'b1;
      end else if (load_use) begin
         bus.pc_write    = 1'b0;
         bus.ifid_write  = 1'b0;
         bus.idex_bubble = 1'b1;
      end else if (bus.id_redirect) begin
         bus.ifid_flush = 1'b1;
      end
   end

   // Sequencer state, the done pulse and the stall counter. Reset aborts any freeze.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         md_cnt      <= 4'd0;
         md_done_q   <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         state     <= state_nxt;
         md_cnt    <= md_cnt_nxt;
         md_done_q <= md_done_nxt;
         if (!bus.pc_write)
            stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   assign bus.md_done   = md_done_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MD_LAT=8. It covers load-use,
// the $zero exclusion, rt hazards, redirect priority, the mul/div freeze,
// reset in the middle of a freeze, and saturation of the stall counter.
module tb_pipeline_hazard_ctrl;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   pipeline_hazard_ctrl_if hif();

   pipeline_hazard_ctrl #(.MD_LAT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare all five pipeline controls in one call.
   task automatic chk_ctl(input string tag, input logic pw, input logic iw,
                          input logic fl, input logic bb, input logic hd);
      chk({tag, ".pc_write"},    {15'd0, hif.pc_write},    {15'd0, pw});
      chk({tag, ".ifid_write"},  {15'd0, hif.ifid_write},  {15'd0, iw});
      chk({tag, ".ifid_flush"},  {15'd0, hif.ifid_flush},  {15'd0, fl});
      chk({tag, ".idex_bubble"}, {15'd0, hif.idex_bubble}, {15'd0, bb});
      chk({tag, ".ex_hold"},     {15'd0, hif.ex_hold},     {15'd0, hd});
   endtask

   task automatic clear_inputs();
      hif.id_rs       = 5'd0;
      hif.id_rt       = 5'd0;
      hif.id_uses_rt  = 1'b0;
      hif.ex_memread  = 1'b0;
      hif.ex_wr_reg   = 5'd0;
      hif.ex_md_start = 1'b0;
      hif.id_redirect = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      clear_inputs();

      // Behaviour while reset is asserted.
      tick();
      #1;
      chk_ctl("rst", 0, 0, 0, 0, 0);
      chk("rst.stall_cnt", hif.stall_cnt, 16'd0);
      chk("rst.md_done", {15'd0, hif.md_done}, 16'd0);

      reset = 1'b0;
      #1;
      chk_ctl("idle", 1, 1, 0, 0, 0);

      // A load into r8 with the ID instruction reading r8 stalls for one cycle.
      tick();
      hif.ex_memread = 1'b1; hif.ex_wr_reg = 5'd8; hif.id_rs = 5'd8;
      #1;
      chk_ctl("lu", 0, 0, 0, 1, 0);
      tick();
      clear_inputs();
      #1;
      chk("lu.stall_cnt", hif.stall_cnt, 16'd1);
      chk_ctl("lu.after", 1, 1, 0, 0, 0);

      // A load into $zero never causes a hazard.
      hif.ex_memread = 1'b1; hif.ex_wr_reg = 5'd0; hif.id_rs = 5'd0;
      #1;
      chk_ctl("zero", 1, 1, 0, 0, 0);
      tick();
      chk("zero.stall_cnt", hif.stall_cnt, 16'd1);

      // An rt match counts only when the ID instruction actually reads rt.
      hif.ex_memread = 1'b1; hif.ex_wr_reg = 5'd5; hif.id_rs = 5'd3; hif.id_rt = 5'd5;
      hif.id_uses_rt = 1'b0;
      #1;
      chk_ctl("rt.unused", 1, 1, 0, 0, 0);
      hif.id_uses_rt = 1'b1;
      #1;
      chk_ctl("rt.used", 0, 0, 0, 1, 0);
      clear_inputs();
      #1;

      // A redirect alone flushes IF/ID.
      hif.id_redirect = 1'b1;
      #1;
      chk_ctl("redir", 1, 1, 1, 0, 0);
      // A load-use hazard takes priority over a redirect in the same cycle.
      hif.ex_memread = 1'b1; hif.ex_wr_reg = 5'd8; hif.id_rs = 5'd8;
      #1;
      chk_ctl("lu+redir", 0, 0, 0, 1, 0);
      tick();
      hif.ex_memread = 1'b0;
      #1;
      chk_ctl("redir.next", 1, 1, 1, 0, 0);
      chk("redir.stall_cnt", hif.stall_cnt, 16'd2);
      tick();
      clear_inputs();

      // Mul/div freeze: exactly 8 frozen cycles, with load-use and redirect ignored early on.
      hif.ex_md_start = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c < 3) begin
            hif.ex_memread = 1'b1; hif.ex_wr_reg = 5'd8; hif.id_rs = 5'd8;
            hif.id_redirect = 1'b1;
         end else begin
            hif.ex_memread = 1'b0; hif.id_redirect = 1'b0;
         end
         #1;
         chk_ctl($sformatf("md.c%0d", c), 0, 0, 0, 0, 1);
         chk($sformatf("md.c%0d.md_done", c), {15'd0, hif.md_done}, 16'd0);
         tick();
      end
      // Cycle 9: the done pulse appears, and ex_md_start is ignored so the instruction advances.
      #1;
      chk("md.done", {15'd0, hif.md_done}, 16'd1);
      chk_ctl("md.c8", 1, 1, 0, 0, 0);
      chk("md.stall_cnt", hif.stall_cnt, 16'd10);
      tick();
      hif.ex_md_start = 1'b0;
      #1;
      chk("md.done.off", {15'd0, hif.md_done}, 16'd0);
      chk_ctl("md.c9", 1, 1, 0, 0, 0);
      tick();
      chk("md.stall_cnt.end", hif.stall_cnt, 16'd10);

      // Reset during the 4th MD_BUSY cycle aborts the freeze without a done pulse.
      hif.ex_md_start = 1'b1;
      tick();
      tick();
      tick();
      tick();
      chk("mdr.hold.before", {15'd0, hif.ex_hold}, 16'd1);
      reset = 1'b1;
      #1;
      chk_ctl("mdr.in_reset", 0, 0, 0, 0, 0);
      chk("mdr.stall_cnt", hif.stall_cnt, 16'd0);
      tick();
      hif.ex_md_start = 1'b0;
      reset = 1'b0;
      #1;
      chk_ctl("mdr.after", 1, 1, 0, 0, 0);
      chk("mdr.md_done", {15'd0, hif.md_done}, 16'd0);
      tick();
      chk("mdr.md_done.next", {15'd0, hif.md_done}, 16'd0);
      chk("mdr.stall_cnt.next", hif.stall_cnt, 16'd0);

      // Stall-counter saturation with a load-use hazard held for 65540 cycles.
      hif.ex_memread = 1'b1; hif.ex_wr_reg = 5'd9; hif.id_rs = 5'd9;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat.fffe", hif.stall_cnt, 16'hFFFE);
      tick();
      chk("sat.ffff", hif.stall_cnt, 16'hFFFF);
      repeat (5) @(posedge clk);
      #1;
      chk("sat.hold", hif.stall_cnt, 16'hFFFF);
      chk_ctl("sat.ctl", 0, 0, 0, 1, 0);
      clear_inputs();
      tick();
      chk("sat.final", hif.stall_cnt, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
